// File: rtl/mvau_defn.sv
// Shared definitions for the MVAU activation scheduler: lane geometry, FSM state and word type.
package mvau_defn;
   localparam int SIMD  = 4;
   localparam int TSrcI = 4;
   localparam int TI    = SIMD * TSrcI;

   typedef enum logic {FILL = 1'b0, REPLAY = 1'b1} sched_state_t;

   typedef logic [TI-1:0] act_word_t;

   // Counter/address width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mvau_act_buf.sv
// Activation word buffer: one synchronous write port, one combinational read port.
// Depth is rounded up to a power of two so every address value maps to a real entry.
module mvau_act_buf
   import mvau_defn::*;
#(
   parameter int AW = 2
) (
   input  logic            clk,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_addr,
   input  logic [TI-1:0]   i_wr_data,
   input  logic [AW-1:0]   i_rd_addr,
   output logic [TI-1:0]   o_rd_data
);
   act_word_t r_mem [2**AW];

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/mvau_act_sched.sv
// Input-activation scheduler: buffers SF words per vector and replays them NF times with weight addresses.
// Optional MVAU_SCHED_PERF_EN adds saturating stall_cnt / vec_cnt performance counters.
module mvau_act_sched
   import mvau_defn::*;
#(
   parameter int  SF           = 4,
   parameter int  NF           = 3,
   localparam int WMEM_ADDR_BW = clog2_min1(SF * NF)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [TI-1:0]           in_act,
   input  logic                    in_v,
   output logic                    in_rdy,
   output logic [TI-1:0]           act_out,
   output logic                    act_v,
   input  logic                    act_rdy,
   output logic [WMEM_ADDR_BW-1:0] wmem_addr,
   output logic                    sf_last,
   output logic                    nf_last
`ifdef MVAU_SCHED_PERF_EN
   ,
   output logic [31:0]             stall_cnt,
   output logic [31:0]             vec_cnt
`endif
);
   localparam int SF_BW = clog2_min1(SF);
   localparam int NF_BW = clog2_min1(NF);

   sched_state_t          r_state;
   logic [SF_BW-1:0]      r_sf;
   logic [NF_BW-1:0]      r_nf;
   logic                  r_act_v;
   act_word_t             r_act_out;
   logic [WMEM_ADDR_BW-1:0] r_wmem_addr;
   logic                  r_sf_last;
   logic                  r_nf_last;

   logic                  w_adv;
   logic                  w_fill;
   logic                  w_issue;
   logic                  w_sf_end;
   logic                  w_nf_end;
   logic                  w_wr_en;
   act_word_t             w_buf_rd;
   logic [WMEM_ADDR_BW-1:0] w_addr;

   assign w_adv    = !r_act_v || act_rdy;
   assign w_fill   = (r_state == FILL);
   assign in_rdy   = w_fill && w_adv;
   assign w_wr_en  = in_rdy && in_v;
   // In FILL a word issues only on an accepted input; REPLAY issues whenever the output can advance.
   assign w_issue  = w_fill ? w_wr_en : w_adv;
   assign w_sf_end = (r_sf == SF_BW'(SF - 1));
   assign w_nf_end = (r_nf == NF_BW'(NF - 1));
   assign w_addr   = WMEM_ADDR_BW'(32'(r_nf) * 32'(SF) + 32'(r_sf));

   mvau_act_buf #(.AW(SF_BW)) u_buf (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_sf),
      .i_wr_data (in_act),
      .i_rd_addr (r_sf),
      .o_rd_data (w_buf_rd)
   );

   // Sequencing FSM, fold counters and the single output register stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= FILL;
         r_sf        <= '0;
         r_nf        <= '0;
         r_act_v     <= 1'b0;
         r_act_out   <= '0;
         r_wmem_addr <= '0;
         r_sf_last   <= 1'b0;
         r_nf_last   <= 1'b0;
      end else if (w_adv) begin
         r_act_v <= w_issue;
         if (w_issue) begin
            r_act_out   <= w_fill ? in_act : w_buf_rd;
            r_wmem_addr <= w_addr;
            r_sf_last   <= w_sf_end;
            r_nf_last   <= w_nf_end;
            if (w_sf_end) begin
               r_sf <= '0;
               if (w_nf_end) begin
                  r_nf    <= '0;
                  r_state <= FILL;
               end else begin
                  r_nf    <= r_nf + NF_BW'(1);
                  r_state <= REPLAY;
               end
            end else begin
               r_sf <= r_sf + SF_BW'(1);
            end
         end
      end
   end

   assign act_v     = r_act_v;
   assign act_out   = r_act_out;
   assign wmem_addr = r_wmem_addr;
   assign sf_last   = r_sf_last;
   assign nf_last   = r_nf_last;

`ifdef MVAU_SCHED_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_vec_cnt;

   // Saturating stall and completed-vector counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= 32'd0;
         r_vec_cnt   <= 32'd0;
      end else begin
         if (r_act_v && !act_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (w_issue && w_sf_end && w_nf_end && (r_vec_cnt != 32'hFFFF_FFFF)) begin
            r_vec_cnt <= r_vec_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign vec_cnt   = r_vec_cnt;
`endif
endmodule

// File: tb/tb_mvau_act_sched.sv
// Scoreboard bench for mvau_act_sched: SF=4/NF=3 main instance plus an SF=1/NF=1 pass-through instance.
module tb_mvau_act_sched;
   import mvau_defn::*;

   localparam int SF = 4;
   localparam int NF = 3;
   localparam int AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   act_word_t     in_act;
   logic          in_v, in_rdy;
   act_word_t     act_out;
   logic          act_v, act_rdy;
   logic [AW-1:0] wmem_addr;
   logic          sf_last, nf_last;

   act_word_t     d1_in_act, d1_act_out;
   logic          d1_in_v, d1_in_rdy, d1_act_v, d1_act_rdy;
   logic [0:0]    d1_wmem_addr;
   logic          d1_sf_last, d1_nf_last;

`ifdef MVAU_SCHED_PERF_EN
   logic [31:0] stall_cnt, vec_cnt, d1_stall_cnt, d1_vec_cnt;
`endif

   mvau_act_sched #(.SF(SF), .NF(NF)) dut (
      .clk(clk), .rst_n(rst_n), .in_act(in_act), .in_v(in_v), .in_rdy(in_rdy),
      .act_out(act_out), .act_v(act_v), .act_rdy(act_rdy), .wmem_addr(wmem_addr),
      .sf_last(sf_last), .nf_last(nf_last)
`ifdef MVAU_SCHED_PERF_EN
      , .stall_cnt(stall_cnt), .vec_cnt(vec_cnt)
`endif
   );

   mvau_act_sched #(.SF(1), .NF(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_act(d1_in_act), .in_v(d1_in_v), .in_rdy(d1_in_rdy),
      .act_out(d1_act_out), .act_v(d1_act_v), .act_rdy(d1_act_rdy), .wmem_addr(d1_wmem_addr),
      .sf_last(d1_sf_last), .nf_last(d1_nf_last)
`ifdef MVAU_SCHED_PERF_EN
      , .stall_cnt(d1_stall_cnt), .vec_cnt(d1_vec_cnt)
`endif
   );

   typedef struct packed {
      logic [TI-1:0] w;
      logic [AW-1:0] a;
      logic          sl;
      logic          nl;
   } exp_t;

   exp_t      sb[$];
   exp_t      mon_e;
   act_word_t vec [SF];
   int        n_cmp = 0;
   int        n_mis = 0;
   bit        mon_en = 1'b0;
   int        run = 0;
   int        max_run = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every accepted output word.
   always @(negedge clk) begin
      #2;
      if (act_v === 1'b1) begin
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (mon_en && act_v === 1'b1 && act_rdy) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("act_out", act_out, mon_e.w);
            chk("wmem_addr", 32'(wmem_addr), 32'(mon_e.a));
            chk("sf_last", 32'(sf_last), 32'(mon_e.sl));
            chk("nf_last", 32'(nf_last), 32'(mon_e.nl));
         end
      end
   end

   task automatic gen_vec();
      exp_t e;
      for (int s = 0; s < SF; s++) vec[s] = act_word_t'($urandom);
      for (int f = 0; f < NF; f++) begin
         for (int s = 0; s < SF; s++) begin
            e.w  = vec[s];
            e.a  = AW'(f * SF + s);
            e.sl = (s == SF - 1);
            e.nl = (f == NF - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic drive_word(input act_word_t w);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      in_act = w;
      in_v   = 1'b1;
      while (!got && n < 200) begin
         #1;
         got = in_rdy;
         @(negedge clk);
         n++;
      end
      if (!got) chk("in_handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic drive_vec();
      for (int k = 0; k < SF; k++) drive_word(vec[k]);
   endtask

   task automatic wait_addr(input int a);
      int n;
      n = 0;
      while (!(act_v === 1'b1 && 32'(wmem_addr) == a) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("wait_addr_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int  lowc;
      bit  v1;
      act_word_t d1;

      rst_n = 1'b0; in_v = 1'b0; in_act = '0; act_rdy = 1'b1;
      d1_in_v = 1'b0; d1_in_act = '0; d1_act_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_act_v", 32'(act_v), 32'd0);
      chk("rst_act_out", act_out, 32'd0);
      chk("rst_wmem_addr", 32'(wmem_addr), 32'd0);
      chk("rst_sf_last", 32'(sf_last), 32'd0);
      chk("rst_nf_last", 32'(nf_last), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_rdy", 32'(in_rdy), 32'd1);
      mon_en = 1'b1;

      // Single vector at full rate: in_rdy held low for the 8 replay cycles.
      gen_vec();
      drive_vec();
      in_v = 1'b0;
      lowc = 0;
      for (int i = 0; i < 20; i++) begin
         if (!in_rdy) lowc++;
         @(negedge clk);
      end
      chk("in_rdy_low_cycles", 32'(lowc), 32'd8);
      chk("idle_act_v", 32'(act_v), 32'd0);
      chk("sb_drained_1", 32'(sb.size()), 32'd0);

      // Two vectors back-to-back with in_v kept high.
      max_run = 0;
      gen_vec();
      drive_vec();
      gen_vec();
      drive_vec();
      in_v = 1'b0;
      repeat (30) @(negedge clk);
      chk("b2b_run", 32'(max_run), 32'd24);
      chk("sb_drained_2", 32'(sb.size()), 32'd0);

      // Reset in the middle of a vector.
      gen_vec();
      drive_vec();
      in_v = 1'b0;
      wait_addr(9);
      rst_n  = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      chk("midrst_act_v", 32'(act_v), 32'd0);
      chk("midrst_in_rdy", 32'(in_rdy), 32'd1);
`ifdef MVAU_SCHED_PERF_EN
      chk("midrst_stall_cnt", stall_cnt, 32'd0);
      chk("midrst_vec_cnt", vec_cnt, 32'd0);
`endif
      mon_en = 1'b1;

      // Backpressure: 5 stall cycles at addr 6, then 2 at addr 3 of the next vector.
      gen_vec();
      drive_vec();
      in_v = 1'b0;
      wait_addr(6);
      act_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_addr", 32'(wmem_addr), 32'd6);
         chk("stall_word", act_out, vec[2]);
         chk("stall_v", 32'(act_v), 32'd1);
      end
      act_rdy = 1'b1;
      gen_vec();
      drive_vec();
      in_v = 1'b0;
      wait_addr(3);
      act_rdy = 1'b0;
      repeat (2) @(negedge clk);
      chk("stall2_addr", 32'(wmem_addr), 32'd3);
      act_rdy = 1'b1;
      repeat (20) @(negedge clk);
      chk("sb_drained_3", 32'(sb.size()), 32'd0);
`ifdef MVAU_SCHED_PERF_EN
      chk("stall_cnt", stall_cnt, 32'd7);
      chk("vec_cnt", vec_cnt, 32'd2);
`endif

      // SF=1/NF=1 instance: pure pass-through with in_v toggling.
      for (int i = 0; i < 12; i++) begin
         v1 = ((i % 3) != 1);
         d1 = act_word_t'($urandom);
         d1_in_v   = v1;
         d1_in_act = d1;
         #1;
         chk("d1_in_rdy", 32'(d1_in_rdy), 32'd1);
         @(negedge clk);
         chk("d1_act_v", 32'(d1_act_v), 32'(v1));
         if (v1) begin
            chk("d1_act_out", d1_act_out, d1);
            chk("d1_wmem_addr", 32'(d1_wmem_addr), 32'd0);
            chk("d1_flags", {30'd0, d1_sf_last, d1_nf_last}, 32'd3);
         end
      end
      d1_in_v = 1'b0;
      @(negedge clk);

      chk("sb_final_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
